// File: rtl/reg_writeback_if.sv
// -----------------------------------------------------------------------------
// reg_writeback_if
//   Bundles the signals of the register-file writeback unit that travel
//   between the execution units, the decode stage and the register file.
//
//   Result producers (ALU, LSU):
//     alu_valid/alu_ready/alu_rd/alu_data   ALU result handshake
//     lsu_valid/lsu_ready/lsu_rd/lsu_data   LSU load-data handshake
//   Decode:
//     issue_valid/issue_rd                  destination register marked pending
//     busy                                  per-register "write in flight" flags
//   Register file write port:
//     wen/waddr/wdata                       registered write port
//
//   Modports:
//     master  - the surroundings (producers, decode, register file)
//     slave   - the writeback unit itself
// -----------------------------------------------------------------------------
interface reg_writeback_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                       alu_valid;
    logic                       alu_ready;
    logic [ADDR_WIDTH-1:0]      alu_rd;
    logic [DATA_WIDTH-1:0]      alu_data;

    logic                       lsu_valid;
    logic                       lsu_ready;
    logic [ADDR_WIDTH-1:0]      lsu_rd;
    logic [DATA_WIDTH-1:0]      lsu_data;

    logic                       issue_valid;
    logic [ADDR_WIDTH-1:0]      issue_rd;

    logic                       wen;
    logic [ADDR_WIDTH-1:0]      waddr;
    logic [DATA_WIDTH-1:0]      wdata;
    logic [(2**ADDR_WIDTH)-1:0] busy;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output issue_valid, issue_rd,
        input  alu_ready, lsu_ready,
        input  wen, waddr, wdata, busy
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  issue_valid, issue_rd,
        output alu_ready, lsu_ready,
        output wen, waddr, wdata, busy
    );
endinterface

// File: rtl/reg_writeback.sv
// -----------------------------------------------------------------------------
// reg_writeback
//   Writeback unit for the NPC register file. Results from the ALU and the LSU
//   are each captured into a one-entry holding buffer through a valid/ready
//   handshake. A round-robin arbiter drains at most one buffer per cycle into
//   the registered write port; results addressed to x0 consume their slot but
//   never raise wen. A scoreboard of destination registers with writes in
//   flight lets decode stall on read-after-write hazards.
//
//   Ports:
//     clk    in   clock, all state updates on the rising edge
//     rst_n  in   asynchronous, active-low reset
//     bus    slave modport of reg_writeback_if:
//              alu_valid/alu_ready/alu_rd/alu_data  ALU result handshake
//              lsu_valid/lsu_ready/lsu_rd/lsu_data  LSU result handshake
//              issue_valid/issue_rd                 mark issue_rd pending
//              wen/waddr/wdata                      register file write port
//              busy                                 bit r set: write to r pending
//
//   Timing: a result handshaken at edge E is written by the register file at
//   edge E+2 if it wins arbitration immediately. Ready depends only on
//   registered state, so there is no input-to-output combinational path.
// -----------------------------------------------------------------------------
module reg_writeback #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    reg_writeback_if.slave   bus
);

    localparam int NREG = 2**ADDR_WIDTH;

    // Which source wins when both holding buffers are occupied.
    typedef enum logic {
        PRIO_ALU = 1'b0,
        PRIO_LSU = 1'b1
    } prio_t;

    prio_t                  prio;

    // Holding buffers, one per source.
    logic                   alu_buf_valid;
    logic [ADDR_WIDTH-1:0]  alu_buf_rd;
    logic [DATA_WIDTH-1:0]  alu_buf_data;

    logic                   lsu_buf_valid;
    logic [ADDR_WIDTH-1:0]  lsu_buf_rd;
    logic [DATA_WIDTH-1:0]  lsu_buf_data;

    // Registered write port and scoreboard.
    logic                   wen_q;
    logic [ADDR_WIDTH-1:0]  waddr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [NREG-1:0]        busy_q;
    logic [NREG-1:0]        busy_next;

    // Arbitration and handshake decode.
    logic                   alu_grant;
    logic                   lsu_grant;
    logic                   alu_ready;
    logic                   lsu_ready;
    logic                   alu_take;
    logic                   lsu_take;
    logic                   both_valid;
    logic                   any_grant;
    logic [ADDR_WIDTH-1:0]  grant_rd;
    logic [DATA_WIDTH-1:0]  grant_data;

    // -------------------------------------------------------------------------
    // Arbiter: a pure function of the buffer valids and prio, so readies and
    // grants never see the input ports.
    // -------------------------------------------------------------------------
    always_comb begin
        both_valid = alu_buf_valid && lsu_buf_valid;
        alu_grant  = alu_buf_valid && (!lsu_buf_valid || (prio == PRIO_ALU));
        lsu_grant  = lsu_buf_valid && (!alu_buf_valid || (prio == PRIO_LSU));
        any_grant  = alu_grant || lsu_grant;

        grant_rd   = '0;
        grant_data = '0;
        if (alu_grant) begin
            grant_rd   = alu_buf_rd;
            grant_data = alu_buf_data;
        end else if (lsu_grant) begin
            grant_rd   = lsu_buf_rd;
            grant_data = lsu_buf_data;
        end
    end

    // A buffer that is draining this cycle can be refilled at the same edge,
    // which is what lets a lone source sustain one result per cycle.
    always_comb begin
        alu_ready = !alu_buf_valid || alu_grant;
        lsu_ready = !lsu_buf_valid || lsu_grant;
        alu_take  = bus.alu_valid && alu_ready;
        lsu_take  = bus.lsu_valid && lsu_ready;
    end

    // -------------------------------------------------------------------------
    // Scoreboard next state. The clear is applied first so that a new issue to
    // the register being written in the same cycle keeps its bit set.
    // -------------------------------------------------------------------------
    always_comb begin
        busy_next = busy_q;
        if (wen_q) begin
            busy_next[waddr_q] = 1'b0;
        end
        if (bus.issue_valid && (bus.issue_rd != '0)) begin
            busy_next[bus.issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // -------------------------------------------------------------------------
    // State: buffers, round-robin pointer, write port and scoreboard.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio          <= PRIO_LSU;
            alu_buf_valid <= 1'b0;
            alu_buf_rd    <= '0;
            alu_buf_data  <= '0;
            lsu_buf_valid <= 1'b0;
            lsu_buf_rd    <= '0;
            lsu_buf_data  <= '0;
            wen_q         <= 1'b0;
            waddr_q       <= '0;
            wdata_q       <= '0;
            busy_q        <= '0;
        end else begin
            // ALU holding buffer
            if (alu_take) begin
                alu_buf_valid <= 1'b1;
                alu_buf_rd    <= bus.alu_rd;
                alu_buf_data  <= bus.alu_data;
            end else if (alu_grant) begin
                alu_buf_valid <= 1'b0;
            end

            // LSU holding buffer
            if (lsu_take) begin
                lsu_buf_valid <= 1'b1;
                lsu_buf_rd    <= bus.lsu_rd;
                lsu_buf_data  <= bus.lsu_data;
            end else if (lsu_grant) begin
                lsu_buf_valid <= 1'b0;
            end

            // Round-robin: hand priority to the loser after every contended cycle.
            if (both_valid) begin
                prio <= (prio == PRIO_LSU) ? PRIO_ALU : PRIO_LSU;
            end

            // Write port: an x0 result still drains its buffer but stays silent.
            if (any_grant) begin
                wen_q   <= (grant_rd != '0);
                waddr_q <= grant_rd;
                wdata_q <= grant_data;
            end else begin
                wen_q   <= 1'b0;
            end

            busy_q <= busy_next;
        end
    end

    assign bus.alu_ready = alu_ready;
    assign bus.lsu_ready = lsu_ready;
    assign bus.wen       = wen_q;
    assign bus.waddr     = waddr_q;
    assign bus.wdata     = wdata_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_reg_writeback.sv
// -----------------------------------------------------------------------------
// tb_reg_writeback
//   Self-checking bench for reg_writeback. A behavioural model keeps each
//   source's pending result in a queue (capacity one), remembers whose turn a
//   tie is, and tracks the expected write port and busy flags. Every cycle
//   the DUT outputs are compared against the model at the falling edge, then
//   new inputs are driven and the model advanced to the next rising edge.
// -----------------------------------------------------------------------------
module tb_reg_writeback;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    reg_writeback_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    reg_writeback #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } res_t;

    // Reference model state
    res_t            alu_q[$];
    res_t            lsu_q[$];
    bit              lsu_turn;
    logic            m_wen;
    logic [AW-1:0]   m_waddr;
    logic [DW-1:0]   m_wdata;
    logic [NREG-1:0] m_busy;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // 0: nobody, 1: ALU, 2: LSU
    function automatic int winner();
        if (alu_q.size() != 0 && lsu_q.size() != 0) return lsu_turn ? 2 : 1;
        if (alu_q.size() != 0) return 1;
        if (lsu_q.size() != 0) return 2;
        return 0;
    endfunction

    function automatic bit m_alu_ready();
        return (alu_q.size() == 0) || (winner() == 1);
    endfunction

    function automatic bit m_lsu_ready();
        return (lsu_q.size() == 0) || (winner() == 2);
    endfunction

    task automatic model_reset();
        alu_q.delete();
        lsu_q.delete();
        lsu_turn = 1'b1;
        m_wen    = 1'b0;
        m_waddr  = '0;
        m_wdata  = '0;
        m_busy   = '0;
    endtask

    // Advance the model across one rising edge using the inputs now driven.
    task automatic model_edge();
        int   w;
        bit   ar;
        bit   lr;
        res_t g;
        res_t r;
        w  = winner();
        ar = m_alu_ready();
        lr = m_lsu_ready();
        if (m_wen) m_busy[m_waddr] = 1'b0;
        if (bus.issue_valid && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1'b1;
        if (alu_q.size() != 0 && lsu_q.size() != 0) lsu_turn = !lsu_turn;
        g = '0;
        if (w == 1) g = alu_q.pop_front();
        else if (w == 2) g = lsu_q.pop_front();
        if (w != 0) begin
            m_wen   = (g.rd != 0);
            m_waddr = g.rd;
            m_wdata = g.data;
        end else begin
            m_wen = 1'b0;
        end
        if (bus.alu_valid && ar) begin
            r.rd = bus.alu_rd; r.data = bus.alu_data;
            alu_q.push_back(r);
        end
        if (bus.lsu_valid && lr) begin
            r.rd = bus.lsu_rd; r.data = bus.lsu_data;
            lsu_q.push_back(r);
        end
    endtask

    task automatic check_outputs(input string where);
        check({where, ".wen"},       bus.wen,       m_wen);
        check({where, ".waddr"},     bus.waddr,     m_waddr);
        check({where, ".wdata"},     bus.wdata,     m_wdata);
        check({where, ".busy"},      bus.busy,      m_busy);
        check({where, ".alu_ready"}, bus.alu_ready, m_alu_ready());
        check({where, ".lsu_ready"}, bus.lsu_ready, m_lsu_ready());
    endtask

    task automatic drive(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                         input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld,
                         input logic iv, input logic [AW-1:0] ird);
        bus.alu_valid   = av;
        bus.alu_rd      = ard;
        bus.alu_data    = ad;
        bus.lsu_valid   = lv;
        bus.lsu_rd      = lrd;
        bus.lsu_data    = ld;
        bus.issue_valid = iv;
        bus.issue_rd    = ird;
    endtask

    // One clock cycle: check outputs, drive inputs, step the model.
    task automatic cyc(input string where,
                       input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                       input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld,
                       input logic iv, input logic [AW-1:0] ird);
        @(negedge clk);
        check_outputs(where);
        drive(av, ard, ad, lv, lrd, ld, iv, ird);
        model_edge();
    endtask

    task automatic idle(input string where, input int n);
        for (int i = 0; i < n; i++) cyc(where, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    initial begin
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
        model_reset();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_outputs("reset");
        rst_n = 1'b1;

        // Single ALU stream rd=1..8, data=rd*0x11
        for (int i = 1; i <= 8; i++)
            cyc("alu_stream", 1'b1, AW'(i), DW'(i * 32'h11), 1'b0, '0, '0, 1'b0, '0);
        idle("alu_drain", 4);

        // Contention: both sources valid every cycle
        for (int i = 0; i < 10; i++)
            cyc("contend", 1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB, 1'b0, '0);
        idle("contend_drain", 4);

        // x0 result from the LSU
        cyc("x0", 1'b0, '0, '0, 1'b1, 5'd0, 32'hDEAD, 1'b0, '0);
        idle("x0_drain", 3);

        // Scoreboard: issue 5, ALU writes back 5, busy clears
        cyc("sb_issue", 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd5);
        idle("sb_wait", 2);
        cyc("sb_alu", 1'b1, 5'd5, 32'h55, 1'b0, '0, '0, 1'b0, '0);
        idle("sb_clear", 4);

        // Scoreboard: re-issue 5 in the cycle wen=1/waddr=5 -> set wins
        cyc("sb2_issue", 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd5);
        cyc("sb2_alu", 1'b1, 5'd5, 32'h66, 1'b0, '0, '0, 1'b0, '0);
        idle("sb2_gap", 1);
        cyc("sb2_reissue", 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd5);
        idle("sb2_hold", 3);
        cyc("sb2_final", 1'b0, '0, '0, 1'b1, 5'd5, 32'h77, 1'b0, '0);
        idle("sb2_drain", 4);

        // Issue rd=0 never marks anything
        cyc("issue_x0", 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd0);
        idle("issue_x0_chk", 2);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            cyc("rand",
                $urandom_range(0, 3) != 0, AW'($urandom_range(0, NREG - 1)), $urandom,
                $urandom_range(0, 2) != 0, AW'($urandom_range(0, NREG - 1)), $urandom,
                $urandom_range(0, 3) == 0, AW'($urandom_range(0, NREG - 1)));
        end
        idle("rand_drain", 4);

        // Mid-stream reset with both buffers full and writes pending
        cyc("pre_rst_issue", 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9);
        for (int i = 0; i < 4; i++)
            cyc("pre_rst", 1'b1, 5'd7, 32'h700 + i, 1'b1, 5'd8, 32'h800 + i, 1'b0, '0);
        @(negedge clk);
        check_outputs("pre_rst_last");
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("in_rst");
        @(negedge clk);
        check_outputs("in_rst_hold");
        rst_n = 1'b1;
        idle("post_rst", 3);

        // Short burst after reset to confirm recovery
        for (int i = 0; i < 6; i++)
            cyc("post_rst_burst", 1'b1, AW'(i + 10), DW'(i + 100), 1'b1, AW'(i + 20), DW'(i + 200), 1'b0, '0);
        idle("final_drain", 4);

        @(negedge clk);
        check_outputs("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Writeback unit driving the write port (wen/waddr/wdata) of the NPC register file. It accepts results from the ALU and the load/store unit (LSU) through valid/ready handshakes and buffers one result per source. It arbitrates round-robin, issues at most one register write per cycle and suppresses writes to x0. It also keeps a scoreboard of destination registers with writes in flight, so the decode stage can stall on read-after-write hazards.

## Interface
- ADDR_WIDTH, 5, register address width; the register file holds 2**ADDR_WIDTH entries
- DATA_WIDTH, 32, register data width

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result valid
- alu_ready  out  1  ALU result accepted this edge when alu_valid=1
- alu_rd  in  ADDR_WIDTH  ALU destination register
- alu_data  in  DATA_WIDTH  ALU result
- lsu_valid  in  1  LSU result valid
- lsu_ready  out  1  LSU result accepted this edge when lsu_valid=1
- lsu_rd  in  ADDR_WIDTH  LSU destination register
- lsu_data  in  DATA_WIDTH  LSU load data
- issue_valid  in  1  decode issues an instruction that writes issue_rd
- issue_rd  in  ADDR_WIDTH  destination to mark pending
- wen  out  1  register file write enable (registered)
- waddr  out  ADDR_WIDTH  register file write address (registered)
- wdata  out  DATA_WIDTH  register file write data (registered)
- busy  out  2**ADDR_WIDTH  bit r=1: write to register r in flight (registered)

## Operation
- Per source, there is a one-entry holding buffer (buf_valid, buf_rd, buf_data). Handshake occurs at an edge where valid && ready; the buffer captures rd/data there.
- Arbiter inputs are alu_buf_valid and lsu_buf_valid only. Grants are a pure function of registered state and never depend on input ports.
  - Only one buffer is valid: that buffer is granted.
  - Both buffers are valid: the source whose prio bit is set is granted.
  - prio flips to the other source after every cycle with both buffers valid.
  - Reset prio = LSU.
- Ready rule: x_ready = !x_buf_valid || x_grant. A granted buffer may be refilled at the same edge it drains.
- Output register on a grant:
  - wdata <= granted data and waddr <= granted rd.
  - wen <= 1 if rd != 0; wen <= 0 if rd == 0. An x0 result still consumes its slot.
  - No grant: wen <= 0; waddr/wdata hold their values.
- Scoreboard busy:
  - Set: issue_valid && issue_rd != 0 sets busy[issue_rd].
  - Clear: wen && waddr == r clears busy[r] at the edge the register file performs that write.
  - Set and clear of the same register at the same edge: set wins.
  - busy[0] is constant 0.
- No checking of multiple in-flight writers to one register. The first write clears the bit; correct ordering is decode's responsibility.

## Timing
- Reset (asynchronous, immediate on rst_n=0):
  - wen=0, waddr=0, wdata=0, busy=0.
  - Both buffers empty, so alu_ready=lsu_ready=1.
  - prio=LSU.
- Mid-operation reset discards buffered results and the pending wen. No write occurs after rst_n falls.
- Latency:
  - Handshake at edge E; buffered during cycle E..E+1.
  - If granted, wen=1 during the cycle following edge E+1.
  - Register file writes and busy clears at edge E+2.
- Loser of arbitration: waits one more cycle per lost round. With round-robin, its maximum wait is one cycle.
- Throughput:
  - One write per cycle total.
  - A single active source sustains one result per cycle (ready stays 1).
  - Under contention each source gets one write every 2 cycles. Each loser's ready=0 while it is held.
- No combinational path from any input to any output. alu_ready/lsu_ready depend on registered state only.

## Test plan
- Reset: assert rst_n=0 mid-stream with both buffers full -> wen=0, busy=0, both readys=1 immediately. No write to the register file.
- Single ALU stream with rd=1..8 and data=rd*0x11 on consecutive cycles -> alu_ready stays 1. wen is high for 8 consecutive cycles, starting 2 edges after the first handshake, with waddr=1..8 and wdata=0x11..0x88 in order.
- Contention: ALU and LSU both valid each cycle (ALU rd=3/data=0xA, LSU rd=4/data=0xB) -> writes alternate LSU, ALU, LSU, ... Each ready toggles 1/0, and no result is lost or duplicated.
- x0: LSU rd=0, data=0xDEAD -> handshake completes and the slot is consumed. wen=0 in the output cycle; busy unchanged.
- Scoreboard: issue rd=5 -> busy[5]=1. ALU returns rd=5 -> busy[5] clears at the edge where wen=1 and waddr=5. Repeat with issue_rd=5 in that same cycle -> busy[5] stays 1.
- Issue rd=0 -> busy stays all zero.
